// File: rtl/cpu_timing_sequencer.sv
// -----------------------------------------------------------------------------
// cpu_timing_sequencer
//   T-state sequencer and instruction register for the 6502 core. It produces
//   the one-hot timing vector and the opcode / inverted-opcode buses for the
//   decode ROM. It steps T-states from the decode ROM's last-cycle and short
//   lines, latches NMI edges, samples IRQ, and forces the BRK opcode into IR at
//   instruction boundaries when a request is pending.
//
// Ports
//   clk           core clock, rising edge
//   rst_n         asynchronous active-low reset
//   rdy_i         1 = advance, 0 = stall (state, IR, int_src frozen)
//   data_i        data bus, opcode captured on the T0->T1 edge
//   last_cycle_i  decode ROM: current cycle ends the instruction
//   short_i       decode ROM: skip one T-state
//   i_flag_i      P.I, masks IRQ
//   irq_n_i       IRQ request, level, active-low
//   nmi_n_i       NMI request, falling edge, asynchronous to clk
//   timing_o      one-hot T-state (bit k = Tk)
//   sync_o        opcode fetch cycle (T0)
//   ir_o          instruction register
//   ir_n_o        ~ir_o[6:0] for the decode ROM
//   int_src_o     injected sequence source: 00 none, 01 IRQ, 10 NMI, 11 reset
//   pc_hold_o     inhibit PC increment in T0 of an injected sequence
// -----------------------------------------------------------------------------
module cpu_timing_sequencer #(
   parameter logic [7:0] INJECT_OPCODE = 8'h00,
   parameter int         NMI_SYNC      = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rdy_i,
   input  logic [7:0] data_i,
   input  logic       last_cycle_i,
   input  logic       short_i,
   input  logic       i_flag_i,
   input  logic       irq_n_i,
   input  logic       nmi_n_i,
   output logic [5:0] timing_o,
   output logic       sync_o,
   output logic [7:0] ir_o,
   output logic [6:0] ir_n_o,
   output logic [1:0] int_src_o,
   output logic       pc_hold_o
);

   // The state encoding is the timing vector itself, so timing_o needs no decode.
   typedef enum logic [5:0] {
      T0 = 6'b000001,
      T1 = 6'b000010,
      T2 = 6'b000100,
      T3 = 6'b001000,
      T4 = 6'b010000,
      T5 = 6'b100000
   } tstate_e;

   tstate_e             state_q, state_d;
   logic [7:0]          ir_q, ir_d;
   logic [1:0]          src_q, src_d;
   logic [NMI_SYNC-1:0] nmi_sync_q;
   logic                nmi_dly_q;
   logic                nmi_pend_q, nmi_pend_d;
   logic                nmi_fall;
   logic                irq_pend;
   logic                nmi_take;

   // Falling edge of the synchronised NMI line; runs regardless of rdy_i.
   assign nmi_fall = nmi_dly_q & ~nmi_sync_q[NMI_SYNC-1];
   assign irq_pend = ~irq_n_i & ~i_flag_i;

   // ---- register stage ----
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= T0;
         ir_q       <= INJECT_OPCODE;
         src_q      <= 2'b11;
         nmi_sync_q <= '1;
         nmi_dly_q  <= 1'b1;
         nmi_pend_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         ir_q          <= ir_d;
         src_q         <= src_d;
         nmi_sync_q[0] <= nmi_n_i;
         for (int i = 1; i < NMI_SYNC; i++)
            nmi_sync_q[i] <= nmi_sync_q[i-1];
         nmi_dly_q     <= nmi_sync_q[NMI_SYNC-1];
         nmi_pend_q    <= nmi_pend_d;
      end
   end

   // ---- next-state stage ----
   always_comb begin
      state_d  = state_q;
      ir_d     = ir_q;
      src_d    = src_q;
      nmi_take = 1'b0;
      if (rdy_i) begin
         unique case (state_q)
            T0: begin
               state_d = T1;
               if (nmi_pend_q) begin
                  ir_d     = INJECT_OPCODE;
                  src_d    = 2'b10;
                  nmi_take = 1'b1;
               end else if (irq_pend) begin
                  ir_d  = INJECT_OPCODE;
                  src_d = 2'b01;
               end else begin
                  ir_d  = data_i;
                  src_d = 2'b00;
               end
            end
            T1:      state_d = last_cycle_i ? T0 : (short_i ? T3 : T2);
            T2:      state_d = last_cycle_i ? T0 : (short_i ? T4 : T3);
            T3:      state_d = last_cycle_i ? T0 : (short_i ? T5 : T4);
            T4:      state_d = last_cycle_i ? T0 : T5;
            T5:      state_d = T0;
            default: state_d = T0;
         endcase
         // Instruction boundary ends any injected sequence.
         if (state_q != T0 && state_d == T0)
            src_d = 2'b00;
      end
      // A new edge wins over the clear so an NMI during an NMI sequence is kept.
      nmi_pend_d = (nmi_pend_q & ~nmi_take) | nmi_fall;
   end

   assign timing_o  = state_q;
   assign sync_o    = state_q[0];
   assign ir_o      = ir_q;
   assign ir_n_o    = ~ir_q[6:0];
   assign int_src_o = src_q;
   assign pc_hold_o = state_q[0] & (src_q != 2'b00);

endmodule

// File: tb/tb_cpu_timing_sequencer.sv
module tb_cpu_timing_sequencer;

   localparam int         S   = 2;
   localparam logic [7:0] INJ = 8'h00;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rdy_i = 1'b1;
   logic [7:0] data_i = 8'h00;
   logic       last_cycle_i = 1'b0;
   logic       short_i = 1'b0;
   logic       i_flag_i = 1'b1;
   logic       irq_n_i = 1'b1;
   logic       nmi_n_i = 1'b1;
   logic [5:0] timing_o;
   logic       sync_o;
   logic [7:0] ir_o;
   logic [6:0] ir_n_o;
   logic [1:0] int_src_o;
   logic       pc_hold_o;

   int checks = 0;
   int errors = 0;

   // Reference model: T-state as an integer, IR, source, NMI pending flag and
   // a history of nmi_n_i samples (hist[0] = sample at the latest edge).
   int         m_t;
   logic [7:0] m_ir;
   logic [1:0] m_src;
   bit         m_pend;
   bit         hist[$];

   cpu_timing_sequencer #(.INJECT_OPCODE(INJ), .NMI_SYNC(S)) dut (
      .clk(clk), .rst_n(rst_n), .rdy_i(rdy_i), .data_i(data_i),
      .last_cycle_i(last_cycle_i), .short_i(short_i), .i_flag_i(i_flag_i),
      .irq_n_i(irq_n_i), .nmi_n_i(nmi_n_i), .timing_o(timing_o), .sync_o(sync_o),
      .ir_o(ir_o), .ir_n_o(ir_n_o), .int_src_o(int_src_o), .pc_hold_o(pc_hold_o)
   );

   always #5 clk = ~clk;

   // Timing vector must be one-hot whenever out of reset.
   always @(negedge clk) begin
      if (rst_n) begin
         checks++;
         if (!$onehot(timing_o)) begin
            errors++;
            $display("FAIL onehot: timing_o=%b is not one-hot", timing_o);
         end
      end
   end

   task automatic model_reset();
      m_t = 0; m_ir = INJ; m_src = 2'b11; m_pend = 1'b0;
      hist.delete();
      for (int i = 0; i < S + 2; i++) hist.push_back(1'b1);
   endtask

   task automatic model_edge();
      bit fall, took;
      int nt;
      hist.push_front(nmi_n_i);
      if (hist.size() > S + 2) void'(hist.pop_back());
      // A 1->0 change of the line becomes pending S edges after it is first sampled low.
      fall = hist[S+1] && !hist[S];
      took = 1'b0;
      if (rdy_i) begin
         if (m_t == 0) begin
            nt = 1;
            if (m_pend) begin m_ir = INJ; m_src = 2'b10; took = 1'b1; end
            else if (!irq_n_i && !i_flag_i) begin m_ir = INJ; m_src = 2'b01; end
            else begin m_ir = data_i; m_src = 2'b00; end
         end else begin
            if (m_t == 5 || last_cycle_i) nt = 0;
            else if (short_i) nt = (m_t + 2 > 5) ? 5 : m_t + 2;
            else nt = m_t + 1;
            if (nt == 0) m_src = 2'b00;
         end
         m_t = nt;
      end
      m_pend = (m_pend && !took) || fall;
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
   endtask

   task automatic go_t0();
      rdy_i = 1'b1; last_cycle_i = 1'b1; short_i = 1'b0;
      for (int i = 0; i < 8 && m_t != 0; i++) tick();
      last_cycle_i = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      model_reset();
      checks++; if (timing_o !== 6'h01) begin errors++; $display("FAIL rst_timing: got %h exp 01", timing_o); end
      checks++; if (ir_o !== INJ) begin errors++; $display("FAIL rst_ir: got %h exp %h", ir_o, INJ); end
      checks++; if (int_src_o !== 2'b11) begin errors++; $display("FAIL rst_src: got %b exp 11", int_src_o); end
      checks++; if (pc_hold_o !== 1'b1 || sync_o !== 1'b1) begin errors++; $display("FAIL rst_hold_sync: got %b%b exp 11", pc_hold_o, sync_o); end
      checks++; if (ir_n_o !== 7'h7F) begin errors++; $display("FAIL rst_ir_n: got %h exp 7f", ir_n_o); end
   endtask

   task automatic test_reset_seq();
      logic [5:0] seq [6];
      seq = '{6'h02, 6'h04, 6'h08, 6'h10, 6'h20, 6'h01};
      data_i = 8'hEA; last_cycle_i = 1'b0; short_i = 1'b0;
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) begin
         tick();
         checks++;
         if (timing_o !== seq[i]) begin errors++; $display("FAIL rstseq_timing[%0d]: got %h exp %h", i, timing_o, seq[i]); end
      end
      checks++; if (int_src_o !== 2'b00) begin errors++; $display("FAIL rstseq_src_clear: got %b exp 00", int_src_o); end
      tick();
      checks++; if (ir_o !== 8'hEA || int_src_o !== 2'b00) begin errors++; $display("FAIL rstseq_fetch: got ir=%h src=%b exp ir=ea src=00", ir_o, int_src_o); end
      checks++; if (pc_hold_o !== 1'b0) begin errors++; $display("FAIL rstseq_hold: got %b exp 0", pc_hold_o); end
   endtask

   task automatic test_two_cycle();
      go_t0();
      data_i = 8'hA9;
      for (int i = 0; i < 4; i++) begin
         last_cycle_i = (m_t == 1);
         tick();
         checks++;
         if (timing_o !== ((i % 2 == 0) ? 6'h02 : 6'h01)) begin errors++; $display("FAIL twocyc_timing[%0d]: got %h", i, timing_o); end
         checks++;
         if (sync_o !== (i % 2 == 1)) begin errors++; $display("FAIL twocyc_sync[%0d]: got %b exp %b", i, sync_o, (i % 2 == 1)); end
      end
      last_cycle_i = 1'b0;
      checks++; if (ir_o !== 8'hA9 || ir_n_o !== 7'h56) begin errors++; $display("FAIL twocyc_ir: got %h/%h exp a9/56", ir_o, ir_n_o); end
   endtask

   task automatic test_branch();
      go_t0();
      tick(); tick();
      short_i = 1'b1; tick();
      checks++; if (timing_o !== 6'h10) begin errors++; $display("FAIL br_t2_short: got %h exp 10", timing_o); end
      tick();
      checks++; if (timing_o !== 6'h20) begin errors++; $display("FAIL br_t4_short: got %h exp 20", timing_o); end
      tick();
      checks++; if (timing_o !== 6'h01) begin errors++; $display("FAIL br_t5_wrap: got %h exp 01", timing_o); end
      short_i = 1'b0; tick(); tick(); tick();
      short_i = 1'b1; tick();
      checks++; if (timing_o !== 6'h20) begin errors++; $display("FAIL br_t3_short: got %h exp 20", timing_o); end
      short_i = 1'b0; tick();
      tick(); tick(); tick();
      last_cycle_i = 1'b1; short_i = 1'b1; tick();
      checks++; if (timing_o !== 6'h01) begin errors++; $display("FAIL br_last_prio: got %h exp 01", timing_o); end
      last_cycle_i = 1'b0; short_i = 1'b0;
   endtask

   task automatic test_stall();
      go_t0();
      data_i = 8'($urandom_range(1, 255));
      tick(); tick(); tick();
      rdy_i = 1'b0; last_cycle_i = 1'b1; data_i = 8'h00;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if (timing_o !== 6'h08 || ir_o !== m_ir) begin errors++; $display("FAIL stall[%0d]: got t=%h ir=%h exp t=08 ir=%h", i, timing_o, ir_o, m_ir); end
      end
      rdy_i = 1'b1; last_cycle_i = 1'b0; tick();
      checks++; if (timing_o !== 6'h10) begin errors++; $display("FAIL stall_resume: got %h exp 10", timing_o); end
   endtask

   task automatic test_interrupts();
      go_t0();
      data_i = 8'h4C;
      tick(); tick(); tick();
      irq_n_i = 1'b0; i_flag_i = 1'b0; nmi_n_i = 1'b0;
      tick(); tick(); tick();
      checks++; if (timing_o !== 6'h01) begin errors++; $display("FAIL int_reach_t0: got %h exp 01", timing_o); end
      tick();
      checks++; if (int_src_o !== 2'b10 || ir_o !== INJ) begin errors++; $display("FAIL int_nmi: got src=%b ir=%h exp 10/%h", int_src_o, ir_o, INJ); end
      go_t0();
      checks++; if (int_src_o !== 2'b00 || pc_hold_o !== 1'b0) begin errors++; $display("FAIL int_boundary: got src=%b hold=%b exp 00/0", int_src_o, pc_hold_o); end
      tick();
      checks++; if (int_src_o !== 2'b01 || ir_o !== INJ) begin errors++; $display("FAIL int_irq: got src=%b ir=%h exp 01/%h", int_src_o, ir_o, INJ); end
      go_t0();
      i_flag_i = 1'b1; data_i = 8'h5A; tick();
      checks++; if (int_src_o !== 2'b00 || ir_o !== 8'h5A) begin errors++; $display("FAIL int_masked: got src=%b ir=%h exp 00/5a", int_src_o, ir_o); end
      irq_n_i = 1'b1; nmi_n_i = 1'b1;
   endtask

   task automatic test_reset_mid();
      repeat (4) tick();
      go_t0();
      irq_n_i = 1'b0; i_flag_i = 1'b0; tick();
      checks++; if (int_src_o !== 2'b01) begin errors++; $display("FAIL mid_irq: got %b exp 01", int_src_o); end
      irq_n_i = 1'b1; nmi_n_i = 1'b0;
      tick(); tick(); tick();
      checks++; if (timing_o !== 6'h10) begin errors++; $display("FAIL mid_t4: got %h exp 10", timing_o); end
      #2 rst_n = 1'b0;
      #1;
      checks++; if (timing_o !== 6'h01 || ir_o !== INJ || int_src_o !== 2'b11 || pc_hold_o !== 1'b1) begin
         errors++; $display("FAIL mid_async: got t=%h ir=%h src=%b hold=%b exp 01/%h/11/1", timing_o, ir_o, int_src_o, pc_hold_o, INJ);
      end
      nmi_n_i = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      model_reset();
      rst_n = 1'b1;
      for (int i = 0; i < 6; i++) tick();
      data_i = 8'h33; irq_n_i = 1'b1; tick();
      checks++; if (int_src_o !== 2'b00 || ir_o !== 8'h33) begin errors++; $display("FAIL mid_nmi_discard: got src=%b ir=%h exp 00/33", int_src_o, ir_o); end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         rdy_i        = ($urandom_range(0, 99) < 85);
         last_cycle_i = ($urandom_range(0, 99) < 35);
         short_i      = ($urandom_range(0, 99) < 35);
         irq_n_i      = ($urandom_range(0, 7) != 0);
         i_flag_i     = $urandom_range(0, 1);
         data_i       = 8'($urandom);
         if ($urandom_range(0, 9) == 0) nmi_n_i = ~nmi_n_i;
         tick();
         checks++;
         if (timing_o !== 6'(1 << m_t)) begin errors++; $display("FAIL rnd_timing[%0d]: got %h exp %h", i, timing_o, 6'(1 << m_t)); end
         checks++;
         if (ir_o !== m_ir || ir_n_o !== ~m_ir[6:0]) begin errors++; $display("FAIL rnd_ir[%0d]: got %h/%h exp %h", i, ir_o, ir_n_o, m_ir); end
         checks++;
         if (int_src_o !== m_src) begin errors++; $display("FAIL rnd_src[%0d]: got %b exp %b", i, int_src_o, m_src); end
         checks++;
         if (sync_o !== (m_t == 0) || pc_hold_o !== (m_t == 0 && m_src != 2'b00)) begin
            errors++; $display("FAIL rnd_sync_hold[%0d]: got %b%b exp %b%b", i, sync_o, pc_hold_o, (m_t == 0), (m_t == 0 && m_src != 2'b00));
         end
      end
   endtask

   initial begin
      test_reset();
      test_reset_seq();
      test_two_cycle();
      test_branch();
      test_stall();
      test_interrupts();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
